// File: rtl/util_watch_dog_mc.sv
// Multi-channel watchdog: per-channel IDLE/ALIVE/DEAD FSM with down-counter,
// edge-detected heartbeat kicks, optional early-kick window, sticky status and irq.
module util_watch_dog_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] preset,
  input  logic [NUM_CH*CNT_W-1:0] window,
  input  logic [NUM_CH-1:0]       win_en,
  input  logic [NUM_CH-1:0]       monitor_in,
  input  logic [NUM_CH-1:0]       status_clr,
  output logic [NUM_CH-1:0]       state,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       inactive,
  output logic [NUM_CH-1:0]       early,
  output logic [NUM_CH-1:0]       status,
  output logic                    irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIVE = 2'd1,
    S_DEAD  = 2'd2
  } ch_st_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_st_e           fsm_q [NUM_CH];
  ch_st_e           fsm_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] mon_q;
  logic [NUM_CH-1:0] kick;
  logic [NUM_CH-1:0] state_q, state_d;
  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] inactive_q, inactive_d;
  logic [NUM_CH-1:0] early_q, early_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic              irq_q;

  assign kick = monitor_in ^ mon_q;

  always_comb begin
    active_d   = '0;
    inactive_d = '0;
    early_d    = '0;
    state_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fsm_d[i] = fsm_q[i];
      cnt_d[i] = cnt_q[i];
      if (!en[i]) begin
        fsm_d[i] = S_IDLE;
        cnt_d[i] = '0;
      end else begin
        case (fsm_q[i])
          S_IDLE: begin
            if (load[i]) begin
              fsm_d[i]    = S_ALIVE;
              cnt_d[i]    = preset[i*CNT_W +: CNT_W];
              active_d[i] = 1'b1;
            end
          end
          S_ALIVE: begin
            // Priority: load > window violation > kick > timeout
            if (load[i]) begin
              cnt_d[i] = preset[i*CNT_W +: CNT_W];
            end else if (kick[i] && win_en[i] &&
                         (cnt_q[i] > window[i*CNT_W +: CNT_W])) begin
              fsm_d[i]      = S_DEAD;
              cnt_d[i]      = '0;
              early_d[i]    = 1'b1;
              inactive_d[i] = 1'b1;
            end else if (kick[i]) begin
              cnt_d[i] = preset[i*CNT_W +: CNT_W];
            end else if (cnt_q[i] == '0) begin
              fsm_d[i]      = S_DEAD;
              inactive_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
          S_DEAD: begin
            if (load[i] || kick[i]) begin
              fsm_d[i]    = S_ALIVE;
              cnt_d[i]    = preset[i*CNT_W +: CNT_W];
              active_d[i] = 1'b1;
            end else begin
              cnt_d[i] = '0;
            end
          end
          default: begin
            fsm_d[i] = S_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
      state_d[i] = (fsm_d[i] == S_ALIVE);
    end
  end

  // Set dominates clear so a fault coinciding with a clear is never lost
  assign status_d = (status_q & ~status_clr) | inactive_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        fsm_q[i] <= S_IDLE;
        cnt_q[i] <= '0;
      end
      mon_q      <= '0;
      state_q    <= '0;
      active_q   <= '0;
      inactive_q <= '0;
      early_q    <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        fsm_q[i] <= fsm_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      mon_q      <= monitor_in;
      state_q    <= state_d;
      active_q   <= active_d;
      inactive_q <= inactive_d;
      early_q    <= early_d;
      status_q   <= status_d;
      irq_q      <= |status_q;
    end
  end

  assign state    = state_q;
  assign active   = active_q;
  assign inactive = inactive_q;
  assign early    = early_q;
  assign status   = status_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_util_watch_dog_mc.sv
// Directed self-checking bench for util_watch_dog_mc (4 channels, 32-bit counters).
module tb_util_watch_dog_mc;

  localparam int NCH = 4;
  localparam int CW  = 32;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    load;
  logic [NCH*CW-1:0] preset;
  logic [NCH*CW-1:0] window;
  logic [NCH-1:0]    win_en;
  logic [NCH-1:0]    monitor_in;
  logic [NCH-1:0]    status_clr;
  logic [NCH-1:0]    state;
  logic [NCH-1:0]    active;
  logic [NCH-1:0]    inactive;
  logic [NCH-1:0]    early;
  logic [NCH-1:0]    status;
  logic              irq;

  int n_chk  = 0;
  int n_pass = 0;

  util_watch_dog_mc #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .preset     (preset),
    .window     (window),
    .win_en     (win_en),
    .monitor_in (monitor_in),
    .status_clr (status_clr),
    .state      (state),
    .active     (active),
    .inactive   (inactive),
    .early      (early),
    .status     (status),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until inactive[ch] is seen; n = -1 when the budget runs out.
  task automatic wait_inactive(input int ch, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (inactive[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int bad;

    rst = 1'b1; en = '0; load = '0; preset = '0; window = '0;
    win_en = '0; monitor_in = '0; status_clr = '0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_active", active, 0);
    chk("rst_inactive", inactive, 0);
    chk("rst_early", early, 0);
    chk("rst_status", status, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    tick();

    // Timeout on ch0 with preset 0xFF
    en = 4'b0001; preset[0*CW +: CW] = 32'hFF; load = 4'b0001;
    tick();
    load = '0;
    chk("to_active", active, 4'b0001);
    chk("to_state", state, 4'b0001);
    wait_inactive(0, 300, n);
    chk("to_latency", n, 256);
    chk("to_status", status, 4'b0001);
    chk("to_early", early, 0);
    chk("to_irq_pre", irq, 0);
    tick();
    chk("to_irq", irq, 1);
    chk("to_inactive_end", inactive, 0);
    chk("to_state_dead", state, 0);

    status_clr = 4'b0001;
    tick();
    status_clr = '0;
    chk("clr_status", status, 0);
    tick();
    chk("clr_irq", irq, 0);

    // Recovery from DEAD via heartbeat edge
    monitor_in[0] = 1'b1;
    tick();
    chk("rec_active", active, 4'b0001);
    chk("rec_state", state, 4'b0001);

    // Load and violating kick together: load wins, cnt = new preset
    window[0*CW +: CW] = 32'h0; win_en = 4'b0001;
    preset[0*CW +: CW] = 32'h5; load = 4'b0001; monitor_in[0] = 1'b0;
    tick();
    load = '0;
    chk("pri_early", early, 0);
    chk("pri_inactive", inactive, 0);
    chk("pri_state", state, 4'b0001);
    wait_inactive(0, 50, n);
    chk("pri_latency", n, 6);

    // Clear held while a new timeout fires: set wins
    win_en = '0; status_clr = 4'b0001; load = 4'b0001;
    tick();
    load = '0;
    chk("sc_status_clr", status, 0);
    wait_inactive(0, 50, n);
    chk("sc_latency", n, 6);
    chk("sc_status_set", status, 4'b0001);
    status_clr = '0;

    // Keep-alive: preset 0x10, toggle every 8 clocks for 1000 clocks
    preset[0*CW +: CW] = 32'h10; load = 4'b0001;
    tick();
    load = '0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 8 == 0) monitor_in[0] = ~monitor_in[0];
      tick();
      if (!state[0] || inactive[0]) bad++;
    end
    chk("ka_bad_cycles", bad, 0);

    // Window: early kick at 10 clocks is a violation
    preset[0*CW +: CW] = 32'h40; window[0*CW +: CW] = 32'h20; win_en = 4'b0001;
    load = 4'b0001;
    tick();
    load = '0;
    repeat (9) tick();
    monitor_in[0] = ~monitor_in[0];
    tick();
    chk("win_early", early, 4'b0001);
    chk("win_inactive", inactive, 4'b0001);
    chk("win_state", state, 0);

    // Window: kick at 40 clocks is inside the window
    load = 4'b0001;
    tick();
    load = '0;
    repeat (39) tick();
    monitor_in[0] = ~monitor_in[0];
    tick();
    chk("win_ok_early", early, 0);
    chk("win_ok_inactive", inactive, 0);
    chk("win_ok_state", state, 4'b0001);

    // Disable mid-count: IDLE, no pulse, status untouched
    win_en = '0;
    chk("dis_status_pre", status, 4'b0001);
    en = 4'b0000;
    tick();
    chk("dis_state", state, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (inactive != 0 || active != 0) bad++;
      tick();
    end
    chk("dis_no_pulse", bad, 0);
    chk("dis_status_kept", status, 4'b0001);
    status_clr = 4'b0001;
    tick();
    status_clr = '0;
    tick();
    chk("dis_irq_clear", irq, 0);

    // Independence: ch1 times out while ch2 is kept alive
    en = 4'b0110;
    preset[1*CW +: CW] = 32'h3; preset[2*CW +: CW] = 32'h3;
    load = 4'b0110;
    tick();
    load = '0;
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k % 2 == 1) monitor_in[2] = ~monitor_in[2];
      tick();
      if (inactive != 0) begin
        n = k;
        break;
      end
    end
    chk("ind_latency", n, 4);
    chk("ind_inactive", inactive, 4'b0010);
    chk("ind_status", status, 4'b0010);
    chk("ind_state", state, 4'b0100);

    // Asynchronous reset mid-count on all channels
    en = 4'b1111;
    for (int c = 0; c < NCH; c++) preset[c*CW +: CW] = 32'h100;
    load = 4'b1111;
    tick();
    load = '0;
    repeat (3) tick();
    chk("ar_state_pre", state, 4'b1111);
    chk("ar_irq_pre", irq, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", state, 0);
    chk("ar_active", active, 0);
    chk("ar_inactive", inactive, 0);
    chk("ar_early", early, 0);
    chk("ar_status", status, 0);
    chk("ar_irq", irq, 0);
    tick();
    rst = 1'b0;

    // After reset, en alone keeps IDLE; load is needed
    tick();
    chk("post_en_only", state, 0);
    load = 4'b0001;
    tick();
    load = '0;
    chk("post_load_state", state, 4'b0001);
    chk("post_load_active", active, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/util_watch_dog_mc.md
UTIL_WATCH_DOG_MC -- requirements
Module: util_watch_dog_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent watchdog channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 32: timeout counter width in bits (8..32).
REQ-003 SHALL have port clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en  input  NUM_CH  per-channel enable.
REQ-006 SHALL have port load  input  NUM_CH  per-channel preset load strobe.
REQ-007 SHALL have port preset  input  NUM_CH*CNT_W  timeout in clocks; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port window  input  NUM_CH*CNT_W  early-kick threshold, packed like preset.
REQ-009 SHALL have port win_en  input  NUM_CH  per-channel window-mode enable.
REQ-010 SHALL have port monitor_in  input  NUM_CH  monitored heartbeat; any transition is a kick.
REQ-011 SHALL have port status_clr  input  NUM_CH  clears the sticky status bits.
REQ-012 SHALL have port state  output  NUM_CH  1 = channel ALIVE.
REQ-013 SHALL have port active  output  NUM_CH  1-clock pulse on entry to ALIVE.
REQ-014 SHALL have port inactive  output  NUM_CH  1-clock pulse on entry to DEAD.
REQ-015 SHALL have port early  output  NUM_CH  1-clock pulse on a window violation.
REQ-016 SHALL have port status  output  NUM_CH  sticky fault flags.
REQ-017 SHALL have port irq  output  1  OR of all status bits.

Function
REQ-018 Each channel SHALL run an FSM with states IDLE, ALIVE and DEAD, plus a CNT_W-bit down-counter cnt.
REQ-019 Each channel SHALL register monitor_in into mon_q every clock; kick[i] = monitor_in[i] XOR mon_q[i] (both edges count).
REQ-020 With en[i]=0, the channel SHALL go to IDLE on the next edge, set cnt=0, produce no pulses and keep status unchanged.
REQ-021 IDLE SHALL move to ALIVE with cnt=preset on the edge where en=1 and load=1; en=1 alone SHALL keep the channel in IDLE.
REQ-022 In ALIVE, load=1 SHALL reload cnt=preset; otherwise kick=1 SHALL reload cnt=preset; otherwise cnt SHALL decrement by 1 when nonzero.
REQ-023 In ALIVE with cnt==0 and no load or kick, the channel SHALL enter DEAD on that edge; timeout therefore occurs preset+1 clocks after the reload edge.
REQ-024 In ALIVE with win_en=1, a kick while cnt > window (and no load) SHALL be a violation: the channel enters DEAD, sets cnt=0 and pulses early and inactive in the same clock.
REQ-025 In DEAD, kick or load SHALL move the channel to ALIVE with cnt=preset; cnt SHALL otherwise hold 0.
REQ-026 Priority within a clock SHALL be: en=0 > load > window violation > kick > timeout.
REQ-027 active SHALL be registered and SHALL be 1 exactly in the clock after any transition into ALIVE, including from IDLE.
REQ-028 inactive SHALL be registered and SHALL be 1 exactly in the clock after any ALIVE->DEAD transition.
REQ-029 state SHALL be the registered value (FSM==ALIVE).
REQ-030 status[i] SHALL set when inactive[i] pulses and clear on status_clr[i]; set SHALL win when both occur in the same clock.
REQ-031 irq SHALL be registered and equal to the OR of the status bits, with one clock of latency.
REQ-032 preset=0 SHALL give timeout 1 clock after reload; window >= preset SHALL disable violations in practice.
REQ-033 Channels SHALL be fully independent; no event on one channel SHALL affect another.

Reset
REQ-034 rst=1 SHALL asynchronously force every FSM to IDLE, cnt=0, mon_q=0, and state, active, inactive, early, status and irq to 0.
REQ-035 After rst is released, the first IDLE->ALIVE transition SHALL require en=1 with load=1.

Verification
REQ-036 Timeout: ch0 en=1, preset=0xFF, load for 1 clk, no kicks -> active pulse after load; inactive pulse 256 clks after the load edge; status[0]=1; irq=1 one clk later.
REQ-037 Keep-alive: preset=0x10, toggle monitor_in every 8 clks for 1000 clks -> state stays 1 and inactive never pulses.
REQ-038 Window: preset=0x40, window=0x20, win_en=1, kick 10 clks after load -> early and inactive pulse together, state=0; a kick 40 clks after load -> no fault.
REQ-039 Recovery and priority: channel DEAD, toggle monitor_in -> active pulse, state=1; load and kick in the same clock -> cnt=new preset; status_clr and set in the same clock -> status stays 1.
REQ-040 Reset and en: assert rst mid-count on all 4 channels -> all outputs 0 immediately; clear en mid-count -> IDLE with no inactive pulse and status unchanged.
REQ-041 Independence: ch1 times out while ch2 is kicked -> only bit 1 of inactive/status is set.
